// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types and constants for the read initiator and its FIFO.
package axi_lite_pkg;

    localparam int AddrW        = 32;
    localparam int DataW        = 32;
    localparam int BytesPerWord = 4;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    typedef logic [2:0] prot_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; storage is not reset, only the pointers.
module sync_fifo #(
    parameter  int Width = 33,
    parameter  int Depth = 2,
    localparam int CntW  = $clog2(Depth + 1),
    localparam int PtrW  = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic [Width-1:0] rdata,
    output logic [CntW-1:0]  count,
    output logic             full,
    output logic             empty
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CntW'(push) - CntW'(do_pop);
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge aclk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CntW'(Depth));
    assign empty = (count_q == '0);

endmodule

// File: rtl/axi_lite_read_initiator.sv
// AXI4-Lite read master: turns (address, word count) commands into single-beat reads
// with bounded outstanding traffic and streams the returned words out in order.
module axi_lite_read_initiator
    import axi_lite_pkg::*;
#(
    parameter int    Depth  = 2,
    parameter int    LenW   = 8,
    parameter prot_t ArProt = 3'b000
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_addr,
    input  logic [LenW-1:0]  cmd_len,
    output logic [31:0]      araddr,
    output logic             arvalid,
    input  logic             arready,
    output logic [2:0]       arprot,
    input  logic             rvalid,
    output logic             rready,
    input  logic [31:0]      rdata,
    input  logic [1:0]       rresp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_last,
    output logic             busy,
    output logic             err,
    output logic [31:0]      err_addr
);

    localparam int CntW = $clog2(Depth + 1);
    localparam logic [CntW:0] DepthC = (CntW + 1)'(Depth);

    state_e           state_q, state_d;
    logic [AddrW-1:0] base_q, base_d;
    logic [AddrW-1:0] araddr_q, araddr_d;
    logic [AddrW-1:0] err_addr_q, err_addr_d;
    logic [LenW-1:0]  len_q, len_d;
    logic [LenW-1:0]  ar_rem_q, ar_rem_d;
    logic [LenW-1:0]  r_rem_q, r_rem_d;
    logic [CntW-1:0]  inflight_q, inflight_d;
    logic             arvalid_q, arvalid_d;
    logic             err_q, err_d;

    logic             ar_hs, r_hs;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CntW-1:0]  fifo_count, fifo_count_d;
    logic [DataW:0]   fifo_rdata;
    logic [AddrW-1:0] beat_addr;

    assign rready    = (state_q == RUN);
    assign ar_hs     = arvalid_q && arready;
    assign r_hs      = rvalid && rready;
    assign fifo_pop  = !fifo_empty && out_ready;
    // Credits make overflow impossible; the full guard only protects storage.
    assign fifo_push = r_hs && (!fifo_full || fifo_pop);
    assign fifo_count_d = fifo_count + CntW'(fifo_push) - CntW'(fifo_pop);
    assign beat_addr = base_q + (AddrW'(len_q - r_rem_q) << 2);

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        araddr_d   = araddr_q;
        err_addr_d = err_addr_q;
        len_d      = len_q;
        ar_rem_d   = ar_rem_q;
        r_rem_d    = r_rem_q;
        err_d      = err_q;
        inflight_d = inflight_q + CntW'(ar_hs) - CntW'(r_hs);

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    err_d = 1'b0;
                    if (cmd_len != '0) begin
                        base_d     = cmd_addr & ~AddrW'(3);
                        araddr_d   = cmd_addr & ~AddrW'(3);
                        len_d      = cmd_len;
                        ar_rem_d   = cmd_len;
                        r_rem_d    = cmd_len;
                        err_addr_d = '0;
                        state_d    = RUN;
                    end
                end
            end
            RUN: begin
                if (ar_hs) begin
                    araddr_d = araddr_q + AddrW'(BytesPerWord);
                    ar_rem_d = ar_rem_q - 1'b1;
                end
                if (r_hs) begin
                    r_rem_d = r_rem_q - 1'b1;
                    if (rresp != OKAY && !err_q) begin
                        err_d      = 1'b1;
                        err_addr_d = beat_addr;
                    end
                    if (r_rem_q == LenW'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A pending request is never withdrawn; credit only gates raising arvalid.
        arvalid_d = (arvalid_q && !arready) ||
                    (state_d == RUN && ar_rem_d != '0 &&
                     ({1'b0, inflight_d} + {1'b0, fifo_count_d}) < DepthC);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            base_q     <= '0;
            araddr_q   <= '0;
            err_addr_q <= '0;
            len_q      <= '0;
            ar_rem_q   <= '0;
            r_rem_q    <= '0;
            inflight_q <= '0;
            arvalid_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            araddr_q   <= araddr_d;
            err_addr_q <= err_addr_d;
            len_q      <= len_d;
            ar_rem_q   <= ar_rem_d;
            r_rem_q    <= r_rem_d;
            inflight_q <= inflight_d;
            arvalid_q  <= arvalid_d;
            err_q      <= err_d;
        end
    end

    sync_fifo #(
        .Width (DataW + 1),
        .Depth (Depth)
    ) u_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .push    (fifo_push),
        .wdata   ({(r_rem_q == LenW'(1)), rdata}),
        .pop     (fifo_pop),
        .rdata   (fifo_rdata),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign cmd_ready = (state_q == IDLE);
    assign araddr    = araddr_q;
    assign arvalid   = arvalid_q;
    assign arprot    = ArProt;
    assign out_valid = !fifo_empty;
    assign out_data  = fifo_rdata[DataW-1:0];
    assign out_last  = fifo_rdata[DataW];
    assign busy      = (state_q == RUN) || !fifo_empty;
    assign err       = err_q;
    assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_axi_lite_read_initiator.sv
// Randomized bench: a behavioural AXI-Lite responder plus a queue-based reference model of
// the command -> address sequence -> ordered word stream contract.
module tb_axi_lite_read_initiator;

    localparam int Depth = 2;
    localparam int LenW  = 8;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic            cmd_valid, cmd_ready;
    logic [31:0]     cmd_addr;
    logic [LenW-1:0] cmd_len;
    logic [31:0]     araddr;
    logic            arvalid, arready;
    logic [2:0]      arprot;
    logic            rvalid, rready;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            out_valid, out_ready, out_last;
    logic [31:0]     out_data;
    logic            busy, err;
    logic [31:0]     err_addr;

    axi_lite_read_initiator #(.Depth(Depth), .LenW(LenW), .ArProt(3'b000)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .araddr(araddr), .arvalid(arvalid), .arready(arready), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .err(err), .err_addr(err_addr)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errors = 0;

    // Responder / sink knobs
    int ar_pct = 100, r_pct = 100, or_pct = 100, err_pct = 0, err_beat = -1;
    logic [31:0] fixed_data = '0;

    // Reference model state
    logic [31:0] cur_base = '0;
    int          cur_len = 0, ar_issued = 0, beat_cnt = 0;
    int          ar_total = 0, pop_total = 0;
    bit          have_prev = 0;
    bit          exp_err = 0;
    logic [31:0] exp_err_addr = '0;
    logic [32:0] exp_q[$];
    logic [31:0] pend_addr[$];
    bit          pend_last[$];
    logic [31:0] ar_log[$];
    bit          r_hold = 0, r_hs_prev = 0, prev_stall = 0;
    logic [31:0] prev_addr = '0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic clear_model();
        exp_q.delete(); pend_addr.delete(); pend_last.delete(); ar_log.delete();
        ar_issued = 0; cur_len = 0; ar_total = 0; pop_total = 0; beat_cnt = 0;
        have_prev = 0; exp_err = 0; exp_err_addr = '0;
    endtask

    // Responder, stream sink and protocol checks, all decided on the falling edge.
    initial begin
        bit          r_hs_now, is_err;
        logic [32:0] e;
        logic [31:0] a, exp_a;
        arready = 0; rvalid = 0; rdata = '0; rresp = '0; out_ready = 0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                arready = 0; rvalid = 0; out_ready = 0;
                r_hold = 0; r_hs_prev = 0; prev_stall = 0;
                continue;
            end
            if (r_hs_prev) check("out_valid_latency", out_valid, 1);
            if (prev_stall) begin
                check("ar_hold_valid", arvalid, 1);
                check("ar_hold_addr", araddr, prev_addr);
            end
            out_ready = ($urandom_range(99) < or_pct);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("out_unexpected", out_valid, 0);
                else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e[31:0]);
                    check("out_last", out_last, e[32]);
                end
                pop_total++;
            end
            r_hs_now = 0;
            if (!r_hold) begin
                if (pend_addr.size() > 0 && $urandom_range(99) < r_pct) begin
                    rvalid = 1;
                    rdata  = (fixed_data != 0) ? fixed_data : $urandom;
                    is_err = (beat_cnt == err_beat) || ($urandom_range(99) < err_pct);
                    rresp  = is_err ? 2'($urandom_range(3, 1)) : 2'b00;
                end else rvalid = 0;
            end
            if (rvalid) begin
                check("rready_on_rvalid", rready, 1);
                if (rready) begin
                    a = pend_addr.pop_front();
                    exp_q.push_back({pend_last.pop_front(), rdata});
                    if (rresp != 2'b00 && !exp_err) begin
                        exp_err = 1; exp_err_addr = a;
                    end
                    beat_cnt++; r_hold = 0; r_hs_now = 1;
                end else r_hold = 1;
            end
            arready = ($urandom_range(99) < ar_pct);
            if (arvalid && arready) begin
                exp_a = cur_base + 32'(4 * ar_issued);
                check("araddr", araddr, exp_a);
                check("arprot", arprot, 3'b000);
                ar_log.push_back(araddr);
                pend_addr.push_back(exp_a);
                pend_last.push_back(ar_issued == cur_len - 1);
                ar_issued++; ar_total++;
                check("credit", (ar_total - pop_total) <= Depth, 1);
                if (ar_issued > cur_len) check("ar_overrun", ar_issued, cur_len);
            end
            prev_stall = arvalid && !arready;
            prev_addr  = araddr;
            r_hs_prev  = r_hs_now;
        end
    end

    task automatic issue(input logic [31:0] addr, input int len);
        int n = 0;
        @(negedge aclk);
        cmd_valid = 1; cmd_addr = addr; cmd_len = LenW'(len);
        while (!cmd_ready && n < 2000) begin
            @(negedge aclk); n++;
        end
        if (!cmd_ready) check("cmd_accept_timeout", cmd_ready, 1);
        if (have_prev) check("ar_count", ar_issued, cur_len);
        cur_base = addr & ~32'h3; cur_len = len; ar_issued = 0; beat_cnt = 0;
        ar_log.delete(); have_prev = 1;
        exp_err = 0;
        if (len != 0) exp_err_addr = '0;
        @(negedge aclk);
        cmd_valid = 0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((busy || exp_q.size() != 0 || pend_addr.size() != 0) && n < 3000) begin
            @(negedge aclk); n++;
        end
        if (n >= 3000) check("drain_timeout", {busy, exp_q.size() != 0, pend_addr.size() != 0}, 0);
        @(negedge aclk);
        check("ar_count", ar_issued, cur_len);
        check("busy_idle", busy, 0);
        check("err", err, exp_err);
        check("err_addr", err_addr, exp_err_addr);
    endtask

    initial begin
        int p0;
        aresetn = 0; cmd_valid = 0; cmd_addr = '0; cmd_len = '0;
        repeat (3) @(negedge aclk);
        check("rst_arvalid", arvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_err_addr", err_addr, 0);
        check("rst_araddr", araddr, 0);
        aresetn = 1;
        @(negedge aclk);
        check("rst_cmd_ready", cmd_ready, 1);

        // Single read
        fixed_data = 32'hDEADBEEF; p0 = pop_total;
        issue(32'h4, 1);
        wait_done();
        check("single_ar_n", ar_log.size(), 1);
        check("single_ar0", ar_log[0], 32'h4);
        check("single_words", pop_total - p0, 1);
        fixed_data = '0;

        // Four-word burst
        p0 = pop_total;
        issue(32'h100, 4);
        wait_done();
        for (int i = 0; i < 4; i++) check("burst_addr", ar_log[i], 32'h100 + 32'(4 * i));
        check("burst_words", pop_total - p0, 4);

        // Stream backpressure limits outstanding reads to Depth
        or_pct = 0; p0 = pop_total;
        issue(32'h200, 5);
        repeat (30) @(negedge aclk);
        check("bp_ar_n", ar_issued, 2);
        check("bp_arvalid", arvalid, 0);
        check("bp_out_valid", out_valid, 1);
        or_pct = 100;
        wait_done();
        check("bp_words", pop_total - p0, 5);

        // AR stall: request must be held with a stable address
        ar_pct = 0;
        issue(32'h300, 3);
        for (int i = 0; i < 5; i++) begin
            check("stall_arvalid", arvalid, 1);
            check("stall_araddr", araddr, 32'h300);
            @(negedge aclk);
        end
        ar_pct = 100;
        wait_done();

        // Error on the third beat; all words still delivered, err clears on next accept
        err_beat = 2; p0 = pop_total;
        issue(32'h100, 4);
        wait_done();
        check("err_set", err, 1);
        check("err_addr_108", err_addr, 32'h108);
        check("err_words", pop_total - p0, 4);
        err_beat = -1;
        issue(32'h500, 1);
        check("err_clear_on_cmd", err, 0);
        wait_done();

        // Zero-length command clears err and does nothing else
        err_beat = 0;
        issue(32'h600, 2);
        wait_done();
        err_beat = -1; p0 = pop_total;
        issue(32'h700, 0);
        check("zero_err", err, 0);
        check("zero_busy", busy, 0);
        check("zero_arvalid", arvalid, 0);
        wait_done();
        check("zero_words", pop_total - p0, 0);

        // Randomized commands, sometimes issued while the FIFO still drains
        for (int k = 0; k < 30; k++) begin
            ar_pct  = $urandom_range(100, 20);
            r_pct   = $urandom_range(100, 20);
            or_pct  = $urandom_range(100, 10);
            err_pct = ($urandom_range(1) == 1) ? 20 : 0;
            issue($urandom, $urandom_range(9));
            if ($urandom_range(1) == 1) wait_done();
        end
        ar_pct = 100; r_pct = 100; or_pct = 100; err_pct = 0;
        wait_done();

        // Address wrap, then reset in the middle of the burst
        or_pct = 0; err_beat = 0;
        issue(32'hFFFF_FFFC, 4);
        repeat (10) @(negedge aclk);
        check("wrap_ar_n", ar_log.size(), 2);
        check("wrap_ar0", ar_log[0], 32'hFFFF_FFFC);
        check("wrap_ar1", ar_log[1], 32'h0);
        check("wrap_err", err, 1);
        check("wrap_err_addr", err_addr, 32'hFFFF_FFFC);
        check("wrap_out_valid", out_valid, 1);
        aresetn = 0;
        #1;
        check("mid_rst_arvalid", arvalid, 0);
        check("mid_rst_rready", rready, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_err_addr", err_addr, 0);
        check("mid_rst_araddr", araddr, 0);
        clear_model();
        err_beat = -1; or_pct = 100;
        repeat (2) @(negedge aclk);
        aresetn = 1;
        p0 = pop_total;
        issue(32'h40, 2);
        wait_done();
        check("post_rst_words", pop_total - p0, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
